// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit, datapath and ALU.
// State codes are visible on the debug port, so their values are fixed.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    localparam logic [5:0] FN_ADD = 6'b100001;
    localparam logic [5:0] FN_SUB = 6'b100011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_BUSB    = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       ir_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_ctr;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational op/funct decode to ALU operation and immediate extension.
// valid is low for unsupported R-type functs and unknown opcodes.
module mc_alu_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctr,
    output logic       ext_op,
    output logic       valid
);

    always_comb begin
        alu_ctr = ALU_ADD;
        ext_op  = 1'b0;
        valid   = 1'b0;
        case (op)
            OP_RTYPE: begin
                valid = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctr = ALU_ADD;
                    FN_SUB:  alu_ctr = ALU_SUB;
                    FN_AND:  alu_ctr = ALU_AND;
                    FN_OR:   alu_ctr = ALU_OR;
                    FN_SLT:  alu_ctr = ALU_SLT;
                    default: valid   = 1'b0;
                endcase
            end
            OP_ORI: begin
                alu_ctr = ALU_OR;
                valid   = 1'b1;
            end
            OP_ADDIU, OP_LW, OP_SW: begin
                ext_op = 1'b1;
                valid  = 1'b1;
            end
            OP_BEQ: begin
                alu_ctr = ALU_SUB;
                ext_op  = 1'b1;
                valid   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS-subset datapath, with a wait counter
// that stretches fetch / load / store memory states to MEM_LAT cycles.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       PCWrCond,
    output logic [1:0] PCSrc,
    output logic       IRWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IorD,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALUCtr,
    output logic [3:0] state
);

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    ctrl_t      ctrl, ctrl_out;
    logic       mem_last;
    logic [2:0] dec_alu_ctr;
    logic       dec_ext_op;
    logic       dec_valid;

    // The beq condition is applied in the datapath through PCWrCond.
    logic unused_zero;
    assign unused_zero = zero;

    mc_alu_decode u_alu_decode (
        .op      (op_q),
        .funct   (funct_q),
        .alu_ctr (dec_alu_ctr),
        .ext_op  (dec_ext_op),
        .valid   (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= 4'd0;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    assign mem_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = 4'd0;
        op_d         = op_q;
        funct_d      = funct_q;
        ctrl         = '0;
        ctrl.alu_ctr = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_rd = 1'b1;
                if (mem_last) begin
                    ctrl.ir_wr     = 1'b1;
                    ctrl.pc_wr     = 1'b1;
                    ctrl.pc_src    = PCSRC_ALU;
                    ctrl.alu_src_b = SRCB_FOUR;
                    state_d        = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DECODE: begin
                op_d           = op;
                funct_d        = funct;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                case (op)
                    OP_RTYPE:        state_d = ST_EXEC_R;
                    OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ:          state_d = ST_BRANCH;
                    OP_J:            state_d = ST_JUMP;
                    OP_ORI, OP_ADDIU: state_d = ST_EXEC_I;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_BUSB;
                ctrl.alu_ctr   = dec_alu_ctr;
                // Unsupported funct retires as a NOP without touching the register file.
                state_d        = dec_valid ? ST_WB_R : ST_FETCH;
            end
            ST_WB_R: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_dst = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = dec_ext_op;
                ctrl.alu_ctr   = dec_alu_ctr;
                state_d        = ST_WB_I;
            end
            ST_WB_I: begin
                ctrl.reg_wr = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.ext_op    = 1'b1;
                state_d        = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_last) state_d = ST_MEM_WB;
                else          cnt_d   = cnt_q + 4'd1;
            end
            ST_MEM_WB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_last) state_d = ST_FETCH;
                else          cnt_d   = cnt_q + 4'd1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_BUSB;
                ctrl.alu_ctr    = ALU_SUB;
                ctrl.pc_wr_cond = 1'b1;
                ctrl.pc_src     = PCSRC_ALUOUT;
                state_d         = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_wr  = 1'b1;
                ctrl.pc_src = PCSRC_JUMP;
                state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Hold every strobe and select quiet while reset is applied.
    assign ctrl_out = rst ? '0 : ctrl;

    assign PCWr     = ctrl_out.pc_wr;
    assign PCWrCond = ctrl_out.pc_wr_cond;
    assign PCSrc    = ctrl_out.pc_src;
    assign IRWr     = ctrl_out.ir_wr;
    assign MemRd    = ctrl_out.mem_rd;
    assign MemWr    = ctrl_out.mem_wr;
    assign IorD     = ctrl_out.iord;
    assign RegWr    = ctrl_out.reg_wr;
    assign RegDst   = ctrl_out.reg_dst;
    assign MemtoReg = ctrl_out.mem_to_reg;
    assign ALUSrcA  = ctrl_out.alu_src_a;
    assign ALUSrcB  = ctrl_out.alu_src_b;
    assign ExtOp    = ctrl_out.ext_op;
    assign ALUCtr   = ctrl_out.alu_ctr;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three instances at MEM_LAT 1/2/3, a table of latency and
// strobe-count vectors, hand sequences, and random instructions against a sequence model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwr;
        logic       pcwrc;
        logic [1:0] pcsrc;
        logic       irwr;
        logic       memrd;
        logic       memwr;
        logic       iord;
        logic       regwr;
        logic       regdst;
        logic       m2r;
        logic       asa;
        logic [1:0] asb;
        logic       ext;
        logic [2:0] alu;
    } obs_t;

    typedef struct {
        int         k;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         len;
        int         n_regwr;
        int         n_memwr;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst     [3];
    logic [5:0] op_r    [3];
    logic [5:0] funct_r [3];
    logic       zero_r  [3];
    obs_t       obs_w   [3];
    obs_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pcwr, pcwrc, irwr, memrd, memwr, iord, regwr, regdst, m2r, asa, ext;
        logic [1:0] pcsrc, asb;
        logic [2:0] alu;
        logic [3:0] st;
        multicycle_ctrl #(.MEM_LAT(g + 1)) u_dut (
            .clk(clk), .rst(rst[g]), .op(op_r[g]), .funct(funct_r[g]), .zero(zero_r[g]),
            .PCWr(pcwr), .PCWrCond(pcwrc), .PCSrc(pcsrc), .IRWr(irwr), .MemRd(memrd),
            .MemWr(memwr), .IorD(iord), .RegWr(regwr), .RegDst(regdst), .MemtoReg(m2r),
            .ALUSrcA(asa), .ALUSrcB(asb), .ExtOp(ext), .ALUCtr(alu), .state(st)
        );
        assign obs_w[g] = {st, pcwr, pcwrc, pcsrc, irwr, memrd, memwr, iord,
                           regwr, regdst, m2r, asa, asb, ext, alu};
    end

    function automatic obs_t mk(input logic [3:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic int r_alu(input logic [5:0] f);
        case (f)
            6'b100001: return 0;
            6'b100011: return 1;
            6'b100100: return 2;
            6'b100101: return 3;
            6'b101010: return 4;
            default:   return -1;
        endcase
    endfunction

    // Expand one instruction into its cycle-by-cycle expected control outputs.
    task automatic build(input logic [5:0] op, input logic [5:0] funct, input int lat);
        obs_t o;
        int   a;
        for (int c = 0; c < lat; c++) begin
            o = mk(0); o.memrd = 1;
            if (c == lat - 1) begin o.irwr = 1; o.pcwr = 1; o.asb = 2'd1; end
            exp_q.push_back(o);
        end
        o = mk(1); o.asb = 2'd3; exp_q.push_back(o);
        case (op)
            6'b000000: begin
                a = r_alu(funct);
                o = mk(2); o.asa = 1;
                if (a >= 0) o.alu = 3'(a);
                exp_q.push_back(o);
                if (a >= 0) begin o = mk(3); o.regwr = 1; o.regdst = 1; exp_q.push_back(o); end
            end
            6'b100011, 6'b101011: begin
                o = mk(6); o.asa = 1; o.asb = 2'd2; o.ext = 1; exp_q.push_back(o);
                for (int c = 0; c < lat; c++) begin
                    if (op == 6'b100011) begin o = mk(7); o.memrd = 1; end
                    else begin o = mk(9); o.memwr = 1; end
                    o.iord = 1; exp_q.push_back(o);
                end
                if (op == 6'b100011) begin o = mk(8); o.regwr = 1; o.m2r = 1; exp_q.push_back(o); end
            end
            6'b000100: begin
                o = mk(10); o.asa = 1; o.alu = 3'd1; o.pcwrc = 1; o.pcsrc = 2'd1;
                exp_q.push_back(o);
            end
            6'b000010: begin o = mk(11); o.pcwr = 1; o.pcsrc = 2'd2; exp_q.push_back(o); end
            6'b001101, 6'b001001: begin
                o = mk(4); o.asa = 1; o.asb = 2'd2;
                if (op == 6'b001101) o.alu = 3'd3; else o.ext = 1;
                exp_q.push_back(o);
                o = mk(5); o.regwr = 1; exp_q.push_back(o);
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input int k, input obs_t want, input string name);
        n_chk++;
        if (obs_w[k] !== want) begin
            n_fail++;
            $display("FAIL %s L=%0d: got state=%0d bits=%h, want state=%0d bits=%h",
                     name, k + 1, obs_w[k].st, obs_w[k], want.st, want);
        end
    endtask

    // Park the other instances in reset and bring instance k up at FETCH, count 0.
    task automatic select_dut(input int k);
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        repeat (3) step();
        check(k, mk(0), "reset_hold");
        rst[k] = 1'b0;
        #1;
        n_chk++;
        if (obs_w[k].st !== 4'd0 || obs_w[k].memrd !== 1'b1 || obs_w[k].memwr !== 1'b0 ||
            obs_w[k].regwr !== 1'b0 || obs_w[k].pcwrc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release L=%0d: got state=%0d memrd=%b memwr=%b regwr=%b, want 0 1 0 0",
                     k + 1, obs_w[k].st, obs_w[k].memrd, obs_w[k].memwr, obs_w[k].regwr);
        end
    endtask

    task automatic run_model(input int k, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input string name, input bit scramble);
        obs_t e;
        exp_q.delete();
        build(op, funct, k + 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (scramble && e.st != 4'd1 && e.st != 4'd2) begin
                op_r[k]    = 6'($urandom);
                funct_r[k] = 6'($urandom);
                zero_r[k]  = 1'($urandom);
            end else begin
                op_r[k]    = op;
                funct_r[k] = funct;
                zero_r[k]  = scramble ? 1'($urandom) : zero;
            end
            check(k, e, name);
            step();
        end
    endtask

    task automatic measure(input vec_t v);
        int   len, rw, mw, ov;
        bit   nz, done;
        obs_t o;
        select_dut(v.k);
        op_r[v.k] = v.op; funct_r[v.k] = v.funct; zero_r[v.k] = v.zero;
        len = 0; rw = 0; mw = 0; ov = 0; nz = 0; done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            o = obs_w[v.k];
            if (o.st != 4'd0) nz = 1;
            else if (nz) done = 1;
            if (!done) begin
                len++;
                rw += int'(o.regwr);
                mw += int'(o.memwr);
                if (o.regwr && o.memwr) ov++;
                step();
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: no return to FETCH within 50 cycles", v.name);
        end
        n_chk++;
        if (len != v.len) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", v.name, len, v.len);
        end
        n_chk++;
        if (rw != v.n_regwr || mw != v.n_memwr || ov != 0) begin
            n_fail++;
            $display("FAIL %s strobes: got regwr=%0d memwr=%0d overlap=%0d want %0d %0d 0",
                     v.name, rw, mw, ov, v.n_regwr, v.n_memwr);
        end
    endtask

    initial begin
        vec_t       tbl[16];
        obs_t       e;
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        logic [5:0] rop, rfn;
        int         k;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; op_r[i] = '0; funct_r[i] = '0; zero_r[i] = 1'b0;
        end

        tbl[0]  = '{0, 6'b000000, 6'b100001, 1'b0, 4, 1, 0, "add_L1"};
        tbl[1]  = '{1, 6'b000000, 6'b100011, 1'b0, 5, 1, 0, "sub_L2"};
        tbl[2]  = '{2, 6'b000000, 6'b101010, 1'b0, 6, 1, 0, "slt_L3"};
        tbl[3]  = '{0, 6'b000000, 6'b100100, 1'b0, 4, 1, 0, "and_L1"};
        tbl[4]  = '{1, 6'b000000, 6'b100101, 1'b1, 5, 1, 0, "or_L2"};
        tbl[5]  = '{2, 6'b100011, 6'b010101, 1'b0, 9, 1, 0, "lw_L3"};
        tbl[6]  = '{0, 6'b100011, 6'b000000, 1'b1, 5, 1, 0, "lw_L1"};
        tbl[7]  = '{1, 6'b101011, 6'b000000, 1'b0, 6, 0, 2, "sw_L2"};
        tbl[8]  = '{2, 6'b101011, 6'b100001, 1'b0, 8, 0, 3, "sw_L3"};
        tbl[9]  = '{0, 6'b000100, 6'b000000, 1'b0, 3, 0, 0, "beq0_L1"};
        tbl[10] = '{2, 6'b000100, 6'b000000, 1'b1, 5, 0, 0, "beq1_L3"};
        tbl[11] = '{1, 6'b000010, 6'b000000, 1'b0, 4, 0, 0, "j_L2"};
        tbl[12] = '{0, 6'b001101, 6'b000000, 1'b0, 4, 1, 0, "ori_L1"};
        tbl[13] = '{2, 6'b001001, 6'b000000, 1'b0, 6, 1, 0, "addiu_L3"};
        tbl[14] = '{1, 6'b111111, 6'b100001, 1'b0, 3, 0, 0, "badop_L2"};
        tbl[15] = '{0, 6'b000000, 6'b000000, 1'b0, 3, 0, 0, "badfn_L1"};

        for (int i = 0; i < 16; i++) measure(tbl[i]);

        select_dut(0);
        run_model(0, 6'b000000, 6'b100001, 1'b0, "t2_add_L1", 0);
        select_dut(2);
        run_model(2, 6'b100011, 6'b000000, 1'b0, "t3_lw_L3", 0);
        select_dut(0);
        run_model(0, 6'b000100, 6'b000000, 1'b0, "t4_beq_z0", 0);
        run_model(0, 6'b000100, 6'b000000, 1'b1, "t4_beq_z1", 0);
        run_model(0, 6'b000010, 6'b000000, 1'b0, "t4_j", 0);
        select_dut(1);
        run_model(1, 6'b111111, 6'b100001, 1'b0, "t5_badop", 0);
        run_model(1, 6'b000000, 6'b000000, 1'b0, "t5_badfn", 0);

        // Reset on the first store cycle, then a full instruction proves the counter restarted.
        select_dut(1);
        exp_q.delete();
        build(6'b101011, 6'b000000, 2);
        op_r[1] = 6'b101011; funct_r[1] = 6'b000000;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(1, e, "t6_pre");
            if (e.st == 4'd9) break;
            step();
        end
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        #1;
        e = mk(0); e.memrd = 1;
        check(1, e, "t6_after_rst");
        run_model(1, 6'b000000, 6'b100101, 1'b0, "t6_restart", 0);

        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001101, 6'b001001, 6'b000000};
        fns = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, 2));
            select_dut(k);
            for (int n = 0; n < int'($urandom_range(1, 4)); n++) begin
                rop = ops[$urandom_range(0, 7)];
                if ($urandom_range(0, 7) == 0) rop = 6'($urandom);
                rfn = fns[$urandom_range(0, 5)];
                if ($urandom_range(0, 5) == 0) rfn = 6'($urandom);
                run_model(k, rop, rfn, 1'b0, "rand", 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
